// File: rtl/add_roundkey_pkg.sv
// ============================================================================
// add_roundkey_pkg : shared AES widths, typedefs and pipeline register layout
// Revision 1.0
// ============================================================================
`default_nettype none

package add_roundkey_pkg;

  localparam int STATE_W   = 128;
  localparam int WORD_W    = 32;
  localparam int NUM_WORDS = STATE_W / WORD_W;

  typedef logic [STATE_W-1:0] state_t;
  typedef logic [WORD_W-1:0]  word_t;

  // Data plus valid flag form the whole registered path
  typedef struct packed {
    logic   valid;
    state_t data;
  } pipe_reg_t;

endpackage : add_roundkey_pkg

`default_nettype wire

// File: rtl/add_roundkey_word.sv
// ============================================================================
// add_roundkey_word : XOR of one 32-bit AES column with its round-key word
// Revision 1.0
// ============================================================================
`default_nettype none

module add_roundkey_word
  import add_roundkey_pkg::*;
(
  input  word_t state_word,
  input  word_t key_word,
  output word_t result_word
);

  assign result_word = state_word ^ key_word;

endmodule : add_roundkey_word

`default_nettype wire

// File: rtl/add_roundkey.sv
// ============================================================================
// add_roundkey : AES AddRoundKey with combinational result and optional
//                one-deep valid/ready output register
// Revision 1.0
// ============================================================================
`default_nettype none

module add_roundkey
  import add_roundkey_pkg::*;
#(
  parameter bit PIPE_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STATE_W-1:0] input_state,
  input  logic [STATE_W-1:0] key,
  output logic [STATE_W-1:0] output_state,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] output_state_q
);

  state_t xor_result;

  // Column c occupies the c-th 32-bit word counted from the MSB end
  generate
    for (genvar c = 0; c < NUM_WORDS; c++) begin : g_col
      add_roundkey_word u_word (
        .state_word  (input_state[STATE_W-1-c*WORD_W -: WORD_W]),
        .key_word    (key[STATE_W-1-c*WORD_W -: WORD_W]),
        .result_word (xor_result[STATE_W-1-c*WORD_W -: WORD_W])
      );
    end
  endgenerate

  assign output_state = xor_result;

  generate
    if (PIPE_EN) begin : g_pipe
      pipe_reg_t pipe_q;
      pipe_reg_t pipe_d;
      logic      ready;

      assign ready = !pipe_q.valid || out_ready;

      // A capture overrides a consume, so back-to-back transfers have no bubble
      always_comb begin
        pipe_d = pipe_q;
        if (pipe_q.valid && out_ready) begin
          pipe_d.valid = 1'b0;
        end
        if (in_valid && ready) begin
          pipe_d.valid = 1'b1;
          pipe_d.data  = xor_result;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pipe_q <= '0;
        end else begin
          pipe_q <= pipe_d;
        end
      end

      assign in_ready       = ready;
      assign out_valid      = pipe_q.valid;
      assign output_state_q = pipe_q.data;
    end else begin : g_no_pipe
      assign in_ready       = 1'b1;
      assign out_valid      = 1'b0;
      assign output_state_q = '0;
    end
  endgenerate

endmodule : add_roundkey

`default_nettype wire

// File: tb/tb_add_roundkey.sv
// ============================================================================
// tb_add_roundkey : directed/scoreboard bench for add_roundkey
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_add_roundkey;

  logic         clk;
  logic         rst;
  logic [127:0] input_state;
  logic [127:0] key;
  logic [127:0] output_state;
  logic         in_valid;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] output_state_q;

  int n_checks = 0;
  int n_fail   = 0;
  logic [127:0] sb_q[$];

  add_roundkey #(.PIPE_EN(1'b1)) dut (
    .clk            (clk),
    .rst            (rst),
    .input_state    (input_state),
    .key            (key),
    .output_state   (output_state),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .output_state_q (output_state_q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a transfer happens on the next rising edge whenever valid && ready
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got %h expected none", output_state_q);
      end else begin
        check("sb_data", output_state_q, sb_q.pop_front());
      end
    end
  end

  // Drive one vector, check the combinational result, queue it for the monitor
  task automatic send(input logic [127:0] s, input logic [127:0] k,
                      input logic [127:0] exp, input string name);
    input_state = s;
    key         = k;
    in_valid    = 1'b1;
    #1;
    check(name, output_state, exp);
    sb_q.push_back(exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [127:0] s;
    logic [127:0] k;
    logic [127:0] x_v;
    logic [127:0] y_v;

    rst         = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    input_state = 128'h89c2abb23688ac1c675eb2d4cf2a263e;
    key         = 128'h636a224c2c3d021f797f4f5e2b36011b;
    #1;
    check("rst_out_valid", {127'd0, out_valid}, 128'd0);
    check("rst_q", output_state_q, 128'd0);
    check("rst_in_ready", {127'd0, in_ready}, 128'd1);
    check("comb_in_rst", output_state, 128'heaa889fe1ab5ae031e21fd8ae41c2725);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;

    send(128'h89c2abb23688ac1c675eb2d4cf2a263e, 128'h636a224c2c3d021f797f4f5e2b36011b,
         128'heaa889fe1ab5ae031e21fd8ae41c2725, "fips_vec");
    send(128'h89c2abb23688ac1c675eb2d4cf2a263e, 128'd0,
         128'h89c2abb23688ac1c675eb2d4cf2a263e, "zero_key");
    send(128'd0, 128'hfedcba9876543210ffeeddccbbaa9988,
         128'hfedcba9876543210ffeeddccbbaa9988, "zero_state");
    send({128{1'b1}}, {128{1'b1}}, 128'd0, "ones_ones");
    send({16{8'hA5}}, {16{8'h5A}}, {128{1'b1}}, "a5_5a");
    send({16{8'hAA}}, {16{8'h55}}, {128{1'b1}}, "aa_55");

    for (int i = 0; i < 128; i++) begin
      s = 128'd1 << i;
      k = {4{32'hDEADBEEF}};
      send(s, k, s ^ k, "walk_state");
    end
    for (int i = 0; i < 128; i++) begin
      s = {4{32'hCAFEF00D}};
      k = 128'd1 << i;
      send(s, k, s ^ k, "walk_key");
    end
    for (int i = 0; i < 100; i++) begin
      s = {$urandom(), $urandom(), $urandom(), $urandom()};
      k = {$urandom(), $urandom(), $urandom(), $urandom()};
      send(s, k, s ^ k, "random");
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("drained_valid", {127'd0, out_valid}, 128'd0);

    // Stall: capture X with no consumer, then hold while a new offer is ignored
    x_v       = 128'h0123456789abcdef0011223344556677;
    out_ready = 1'b0;
    send(x_v, 128'd0, x_v, "hold_cap");
    input_state = 128'hffff0000ffff0000ffff0000ffff0000;
    key         = 128'd0;
    in_valid    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("hold_valid", {127'd0, out_valid}, 128'd1);
      check("hold_in_ready", {127'd0, in_ready}, 128'd0);
      check("hold_q", output_state_q, x_v);
      @(posedge clk);
      #1;
    end

    // Consume X and capture Y on the same edge
    y_v       = 128'h5555aaaa5555aaaa0f0f0f0ff0f0f0f0;
    out_ready = 1'b1;
    #1;
    check("release_in_ready", {127'd0, in_ready}, 128'd1);
    send(y_v, 128'd0, y_v, "nobubble_cap");
    check("nobubble_valid", {127'd0, out_valid}, 128'd1);
    check("nobubble_q", output_state_q, y_v);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("consume_valid", {127'd0, out_valid}, 128'd0);
    check("consume_q_hold", output_state_q, y_v);
    check("consume_in_ready", {127'd0, in_ready}, 128'd1);

    // Asynchronous reset mid-hold discards the pending result
    out_ready = 1'b0;
    send(128'h00000000111111112222222233333333, 128'h0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f,
         128'h0f0f0f0f1e1e1e1e2d2d2d2d3c3c3c3c, "rst_cap");
    in_valid = 1'b0;
    #2;
    check("pre_rst_valid", {127'd0, out_valid}, 128'd1);
    rst = 1'b1;
    #1;
    check("async_rst_valid", {127'd0, out_valid}, 128'd0);
    check("async_rst_q", output_state_q, 128'd0);
    check("async_rst_in_ready", {127'd0, in_ready}, 128'd1);
    check("async_rst_comb", output_state, 128'h0f0f0f0f1e1e1e1e2d2d2d2d3c3c3c3c);
    sb_q.delete();
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    send(128'hcafebabecafebabecafebabecafebabe, 128'h11111111222222223333333344444444,
         128'hdbefabafe8dc989cf9cd898d8ebafefa, "first_after_rst");
    check("first_valid", {127'd0, out_valid}, 128'd1);
    check("first_q", output_state_q, 128'hdbefabafe8dc989cf9cd898d8ebafefa);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("sb_empty", 128'(sb_q.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_add_roundkey

`default_nettype wire

// File: doc/add_roundkey.md
ADD_ROUNDKEY -- requirements
Module: add_roundkey

Interface
REQ-001 Parameter PIPE_EN, default 1, meaning 1 = registered output path present; 0 = registered outputs tied to 0 and in_ready tied to 1.
REQ-002 clk  input  1  the block's single clock; all registers use its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 input_state  input  128  AES state; byte 0 = bits [127:120], column-major.
REQ-005 key  input  128  round key, same byte ordering as input_state.
REQ-006 output_state  output  128  combinational result, input_state XOR key.
REQ-007 in_valid  input  1  input_state/key valid for capture into the registered path.
REQ-008 in_ready  output  1  registered path can accept a capture this cycle.
REQ-009 out_valid  output  1  output_state_q holds a result not yet consumed.
REQ-010 out_ready  input  1  downstream consumes output_state_q this cycle.
REQ-011 output_state_q  output  128  registered copy of the XOR result.

Function
REQ-012 output_state SHALL equal input_state XOR key, bit for bit, with zero latency.
REQ-013 output_state SHALL be independent of clk, rst, in_valid and out_ready, including while rst is asserted.
REQ-014 output_state SHALL settle within the same simulation timestep as any input change; no delta-cycle dependence on clocked logic.
REQ-015 in_ready SHALL equal (!out_valid || out_ready).
REQ-016 A capture SHALL occur on a rising clk edge with in_valid && in_ready.
REQ-017 On capture, output_state_q SHALL load input_state XOR key and out_valid SHALL be 1 after the edge; the latency is 1 cycle.
REQ-018 On an out_ready && out_valid edge without a capture, out_valid SHALL clear and output_state_q SHALL hold its value.
REQ-019 On a simultaneous consume and capture, out_valid SHALL stay 1 and output_state_q SHALL take the new result; no bubble is inserted.
REQ-020 While out_valid && !out_ready, output_state_q and out_valid SHALL hold and in_ready SHALL be 0.
REQ-021 in_valid while in_ready = 0 SHALL be ignored; there is no error flag.
REQ-022 X on input_state or key SHALL propagate only to the affected output bits.

Reset
REQ-023 rst assertion SHALL immediately force out_valid = 0 and output_state_q = 0, regardless of clk.
REQ-024 A capture in flight when rst is asserted SHALL be discarded.
REQ-025 After reset, in_ready SHALL be 1.
REQ-026 The first capture SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-027 The shared aes package SHALL hold the state width constant (128), the word width constant (32), and the state_t/word_t typedefs.
REQ-028 A sub-module add_roundkey_word SHALL XOR one 32-bit column; it is instantiated 4 times, columns 0..3 = bits [127:96]..[31:0].
REQ-029 The registered path SHALL be one 129-bit register (data + valid) with no other state.

Verification
REQ-030 input_state 89c2abb23688ac1c675eb2d4cf2a263e, key 636a224c2c3d021f797f4f5e2b36011b -> output_state eaa889fe1ab5ae031e21fd8ae41c2725 after 1 ns.
REQ-031 Zero key -> output_state = input_state; zero state with key fedcba9876543210ffeeddccbbaa9988 -> output_state = key; all-ones XOR all-ones -> 0.
REQ-032 A5 pattern XOR 5A pattern -> all ones; AA pattern XOR 55 pattern -> all ones.
REQ-033 Walking-1 over 128 bits of the state with key DEADBEEF repeated, and over 128 bits of the key with state CAFEF00D repeated -> output_state = state XOR key each step; plus 100 random vectors against the XOR model.
REQ-034 Handshake: capture with out_ready = 0 -> out_valid = 1, in_ready = 0, data held for 3 cycles; raise out_ready with in_valid = 1 -> new data with no bubble; assert rst mid-hold -> out_valid = 0 and output_state_q = 0 immediately.
